// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: pulls words out of a FIFO with one-cycle read latency and
// presents them as a valid/ready stream through a 3-entry output buffer.
// Reads are only issued when the buffer is guaranteed to have room for the
// word, so back-pressure never drops data and rd_en never waits on m_ready.
// Optional feature: define FIFO_RD_STREAMER_CNT_EN to build the 16-bit
// delivered-word counter; otherwise word_cnt is tied to zero.
`timescale 1ns/1ps
module fifo_rd_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 3   // only 3 is supported
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  drain_en,
   input  logic                  flush,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [15:0]           word_cnt,
   output logic                  busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              occ_q, occ_d;
   logic                    inflight_q;
   logic [1:0]              head_q, head_d;
   logic [1:0]              tail_q, tail_d;
   logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
   logic                    push;
   logic                    pop;
   logic                    room;

   // Circular pointer advance over the three buffer slots.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Output decode: read strobe, stream outputs and busy flag.
   always_comb begin
      // Buffered words plus the one in flight must leave a free slot.
      room    = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'(BUF_DEPTH);
      // rd_en is gated by rst_n directly so no read can escape during reset.
      rd_en   = rst_n & drain_en & ~empty & ~flush & room & (state_q != ST_FLUSH);
      m_valid = (occ_q != 2'd0);
      m_data  = m_valid ? buf_q[head_q] : '0;
      busy    = (state_q != ST_IDLE);
   end

   // Buffer bookkeeping: push the arriving word, pop on handshake, flush clears.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      push   = inflight_q & ~flush & (state_q != ST_FLUSH);
      pop    = m_valid & m_ready;
      if (flush) begin
         occ_d  = 2'd0;
         head_d = 2'd0;
         tail_d = 2'd0;
      end else begin
         if (pop)  head_d = ptr_inc(head_q);
         if (push) tail_d = ptr_inc(tail_q);
         case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // FSM next state: flush wins from any state, FLUSH lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  if (rd_en) state_d = ST_RUN;
            ST_RUN:   if ((occ_q == 2'd0) && !inflight_q && !rd_en) state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk_rd or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         inflight_q <= rd_en;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Buffer storage: capture the FIFO word into the tail slot.
   always_ff @(posedge clk_rd) begin
      // NOTE: the data array is deliberately not reset; occ_q == 0 marks every
      // slot invalid and m_data is forced to zero while nothing is valid.
      if (push) buf_q[tail_q] <= data_out;
   end

`ifdef FIFO_RD_STREAMER_CNT_EN
   logic [15:0] word_cnt_q, word_cnt_d;

   // Delivered-word count, wraps naturally at 16 bits.
   always_comb begin
      word_cnt_d = pop ? word_cnt_q + 16'd1 : word_cnt_q;
   end

   // Counter register.
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) word_cnt_q <= 16'd0;
      else        word_cnt_q <= word_cnt_d;
   end

   assign word_cnt = word_cnt_q;
`else
   assign word_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed bench for fifo_rd_streamer. A queue-based
// model of the output buffer is checked against the DUT on every falling
// edge; each scenario also pins hand-computed values.
`timescale 1ns/1ps
module tb_fifo_rd_streamer;

   localparam int DW      = 8;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;

   logic          clk_rd = 1'b0;
   logic          rst_n;
   logic          drain_en;
   logic          flush;
   logic          empty;
   logic [DW-1:0] data_out = '0;
   logic          rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [15:0]   word_cnt;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_rd_streamer #(.DATA_WIDTH(DW), .BUF_DEPTH(3)) dut (
      .clk_rd   (clk_rd),
      .rst_n    (rst_n),
      .drain_en (drain_en),
      .flush    (flush),
      .empty    (empty),
      .data_out (data_out),
      .rd_en    (rd_en),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .word_cnt (word_cnt),
      .busy     (busy)
   );

   always #5 clk_rd = ~clk_rd;

   // Source FIFO: loaded by the stimulus, read data appears one cycle after rd_en.
   logic [DW-1:0] mem [1024];
   int            pushed_total = 0;
   int            popped_total = 0;
   logic          fifo_inf = 1'b0;   // endless source for the counter-wrap run

   assign empty = fifo_inf ? 1'b0 : (pushed_total == popped_total);

   always @(posedge clk_rd) begin
      if (rd_en) begin
         data_out     <= fifo_inf ? DW'(popped_total) : mem[popped_total % 1024];
         popped_total <= popped_total + 1;
      end
   end

   // Reference model: the output buffer as a plain queue of words.
   logic [DW-1:0] mq [$];
   bit            m_inflight = 1'b0;
   int            m_state    = M_IDLE;
   logic [15:0]   m_cnt      = 16'd0;
   int            cyc        = 0;
   bit            m_rd;
   bit            m_quiet;

   function automatic bit exp_rd();
      return rst_n && drain_en && !empty && !flush &&
             ((mq.size() + int'(m_inflight)) < 3) && (m_state != M_FLUSH);
   endfunction

   function automatic logic [15:0] exp_cnt();
`ifdef FIFO_RD_STREAMER_CNT_EN
      return m_cnt;
`else
      return 16'd0;
`endif
   endfunction

   always @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_inflight = 1'b0;
         m_state    = M_IDLE;
         m_cnt      = 16'd0;
      end else begin
         m_rd    = exp_rd();
         m_quiet = (mq.size() == 0) && !m_inflight && !m_rd;
         if ((mq.size() != 0) && m_ready) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (flush) begin
            mq.delete();
            m_state = M_FLUSH;
         end else begin
            if (m_inflight && (m_state != M_FLUSH)) mq.push_back(data_out);
            case (m_state)
               M_IDLE:  if (m_rd) m_state = M_RUN;
               M_RUN:   if (m_quiet) m_state = M_IDLE;
               default: m_state = M_IDLE;
            endcase
         end
         m_inflight = m_rd;
         cyc++;
      end
   end

   // Observation logs written by the monitor.
   int            rd_cyc    [$];
   logic [DW-1:0] beat_data [$];
   int            beat_cyc  [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_rd);
      #1;
   endtask

   task automatic fifo_push(input logic [DW-1:0] v);
      mem[pushed_total % 1024] = v;
      pushed_total++;
   endtask

   task automatic fifo_clear();
      pushed_total = popped_total;
   endtask

   // Compare DUT against the model mid-cycle and log reads and beats.
   task automatic monitor();
      forever begin
         @(negedge clk_rd);
         check("rd_en", 32'(rd_en), 32'(exp_rd()));
         check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
         check("busy", 32'(busy), 32'(m_state != M_IDLE));
         check("word_cnt", 32'(word_cnt), 32'(exp_cnt()));
         if (rd_en) rd_cyc.push_back(cyc);
         if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_cyc.push_back(cyc);
         end
      end
   endtask

   initial begin
      int  b0;
      int  r0;
      bit  done;
      rst_n    = 1'b0;
      drain_en = 1'b0;
      flush    = 1'b0;
      m_ready  = 1'b0;
      fork
         monitor();
      join_none

      // Reset: no read even with data available and drain_en high.
      tick();
      fifo_push(8'h11);
      drain_en = 1'b1;
      tick();
      tick();
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      drain_en = 1'b0;
      fifo_clear();
      rst_n = 1'b1;
      tick();
      tick();

      // Streaming 0x01..0x08 at full rate.
      b0 = beat_data.size();
      r0 = rd_cyc.size();
      for (int i = 1; i <= 8; i++) fifo_push(DW'(i));
      m_ready  = 1'b1;
      drain_en = 1'b1;
      repeat (14) tick();
      check("stream_reads", 32'(rd_cyc.size() - r0), 32'd8);
      check("stream_beats", 32'(beat_data.size() - b0), 32'd8);
      if ((beat_data.size() - b0 >= 8) && (rd_cyc.size() > r0)) begin
         for (int i = 0; i < 8; i++) begin
            check("stream_data", 32'(beat_data[b0+i]), 32'(i + 1));
            check("stream_cycle", 32'(beat_cyc[b0+i]), 32'(rd_cyc[r0] + 2 + i));
         end
      end
`ifdef FIFO_RD_STREAMER_CNT_EN
      check("stream_word_cnt", 32'(word_cnt), 32'd8);
`else
      check("stream_word_cnt", 32'(word_cnt), 32'd0);
`endif
      check("stream_idle", 32'(busy), 32'd0);
      drain_en = 1'b0;
      m_ready  = 1'b0;
      tick();

      // Backpressure: three reads fill the buffer, head holds.
      b0 = beat_data.size();
      r0 = rd_cyc.size();
      for (int i = 0; i < 6; i++) fifo_push(DW'(8'h21 + i));
      drain_en = 1'b1;
      repeat (8) tick();
      check("bp_reads", 32'(rd_cyc.size() - r0), 32'd3);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_m_data", 32'(m_data), 32'h21);
      m_ready = 1'b1;
      repeat (14) tick();
      check("bp_beats", 32'(beat_data.size() - b0), 32'd6);
      if (beat_data.size() - b0 >= 6)
         for (int i = 0; i < 6; i++) check("bp_data", 32'(beat_data[b0+i]), 32'(8'h21 + i));
      drain_en = 1'b0;
      m_ready  = 1'b0;
      tick();

      // Flush with two buffered words and one in flight.
      b0 = beat_data.size();
      r0 = rd_cyc.size();
      for (int i = 0; i < 5; i++) fifo_push(DW'(8'h31 + i));
      drain_en = 1'b1;
      repeat (3) tick();
      check("fl_reads", 32'(rd_cyc.size() - r0), 32'd3);
      check("fl_pre_data", 32'(m_data), 32'h31);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_m_valid", 32'(m_valid), 32'd0);
      check("fl_busy", 32'(busy), 32'd1);
      check("fl_rd_en", 32'(rd_en), 32'd0);
      tick();
      check("fl_idle", 32'(busy), 32'd0);
      check("fl_resume_rd", 32'(rd_en), 32'd1);
      m_ready = 1'b1;
      repeat (8) tick();
      check("fl_beats", 32'(beat_data.size() - b0), 32'd2);
      if (beat_data.size() - b0 >= 2) begin
         check("fl_next_word", 32'(beat_data[b0]), 32'h34);
         check("fl_last_word", 32'(beat_data[b0+1]), 32'h35);
      end
      drain_en = 1'b0;
      m_ready  = 1'b0;
      tick();

      // Empty boundary: a single word.
      drain_en = 1'b1;
      m_ready  = 1'b1;
      tick();
      b0 = beat_data.size();
      r0 = rd_cyc.size();
      fifo_push(8'h5A);
      repeat (8) tick();
      check("eb_reads", 32'(rd_cyc.size() - r0), 32'd1);
      check("eb_beats", 32'(beat_data.size() - b0), 32'd1);
      if (beat_data.size() > b0) check("eb_data", 32'(beat_data[b0]), 32'h5A);
      check("eb_busy", 32'(busy), 32'd0);
      drain_en = 1'b0;
      m_ready  = 1'b0;
      tick();

      // Asynchronous reset with two words buffered and a read being issued.
      for (int i = 0; i < 6; i++) fifo_push(DW'(8'h41 + i));
      drain_en = 1'b1;
      repeat (3) tick();
      m_ready = 1'b1;
      tick();
      check("ar_pre_rd_en", 32'(rd_en), 32'd1);
      check("ar_pre_valid", 32'(m_valid), 32'd1);
      check("ar_pre_data", 32'(m_data), 32'h42);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_rd_en", 32'(rd_en), 32'd0);
      check("ar_m_valid", 32'(m_valid), 32'd0);
      check("ar_m_data", 32'(m_data), 32'd0);
      check("ar_word_cnt", 32'(word_cnt), 32'd0);
      drain_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      b0 = beat_data.size();
      tick();
      tick();
      check("ar_no_valid", 32'(m_valid), 32'd0);
      check("ar_no_beats", 32'(beat_data.size() - b0), 32'd0);
      fifo_clear();

      // Counter wrap: 65537 pops from an endless source.
      fifo_inf = 1'b1;
      b0       = beat_data.size();
      drain_en = 1'b1;
      m_ready  = 1'b1;
      done     = 1'b0;
      for (int i = 0; (i < 70000) && !done; i++) begin
         tick();
         if (beat_data.size() - b0 == 65537) begin
            m_ready  = 1'b0;
            drain_en = 1'b0;
            done     = 1'b1;
         end
      end
      check("wrap_reached", 32'(done), 32'd1);
      tick();
      tick();
`ifdef FIFO_RD_STREAMER_CNT_EN
      check("wrap_word_cnt", 32'(word_cnt), 32'd1);
`else
      check("wrap_word_cnt", 32'(word_cnt), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
